// File: rtl/stage_sequencer_if.sv
// RAM port between the stage sequencer (master) and the memory (slave).
interface stage_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_ready_i;
  logic [DATA_WIDTH-1:0] mem_data_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    input  mem_ready_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    output mem_ready_i,
    output mem_data_i
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer owning the single RAM port,
// with bus timeout, debug halt/single-step and a retired-instruction counter.
module stage_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  stage_sequencer_if.master     mem,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  output logic [DATA_WIDTH-1:0] ir_o,
  output logic [2:0]            stage_o,
  output logic                  readin_a_o,
  output logic                  readin_b_o,
  output logic                  readin_pass_o,
  output logic                  wd_q_o,
  output logic                  pc_readin_o,
  input  logic                  halt_req_i,
  input  logic                  step_i,
  output logic                  halted_o,
  output logic                  bus_err_o,
  output logic [CNT_WIDTH-1:0]  retired_o
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 2) : 1;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [WAIT_W-1:0]     wait_cnt_r;
  logic [DATA_WIDTH-1:0] ir_r;
  logic [CNT_WIDTH-1:0]  retired_r;
  logic                  bus_err_r;
  logic                  step_r;
  logic                  req_s;
  logic                  timeout_s;

  assign req_s     = (state_r == ST_FETCH) || (state_r == ST_MEMORY);
  assign timeout_s = (TIMEOUT > 0) && req_s && !mem.mem_ready_i &&
                     (wait_cnt_r == WAIT_W'(TIMEOUT));

  // Next-state logic; an instruction is only ever left at a stage boundary.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (timeout_s) begin
          state_next_s = ST_ERROR;
        end else if (mem.mem_ready_i) begin
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: state_next_s = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_load_i || is_store_i) begin
          state_next_s = ST_MEMORY;
        end else begin
          state_next_s = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        if (timeout_s) begin
          state_next_s = ST_ERROR;
        end else if (mem.mem_ready_i) begin
          state_next_s = ST_WRITEBACK;
        end else begin
          state_next_s = ST_MEMORY;
        end
      end
      ST_WRITEBACK: begin
        if (halt_req_i || step_r) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (!halt_req_i || step_i) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      ST_ERROR: state_next_s = ST_ERROR;
      default:  state_next_s = ST_ERROR;
    endcase
  end

  // State, instruction register, wait counter, error flag, retire counter and step flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_FETCH;
      ir_r       <= '0;
      wait_cnt_r <= '0;
      retired_r  <= '0;
      bus_err_r  <= 1'b0;
      step_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_FETCH) && mem.mem_ready_i) begin
        ir_r <= mem.mem_data_i;
      end
      // Counter is zero outside request states, so it is clear on entry to FETCH/MEMORY.
      if (req_s && !mem.mem_ready_i) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      if (timeout_s) begin
        bus_err_r <= 1'b1;
      end
      if (state_r == ST_WRITEBACK) begin
        retired_r <= retired_r + CNT_WIDTH'(1);
        step_r    <= 1'b0;
      end else if ((state_r == ST_HALT) && halt_req_i && step_i) begin
        step_r <= 1'b1;
      end
    end
  end

  // Moore output decode; RAM request is also gated by reset so it drops without a clock.
  always_comb begin
    mem.mem_req_o    = 1'b0;
    mem.mem_we_o     = 1'b0;
    mem.mem_addr_o   = '0;
    readin_a_o       = 1'b0;
    readin_b_o       = 1'b0;
    readin_pass_o    = 1'b0;
    wd_q_o           = 1'b0;
    pc_readin_o      = 1'b0;
    halted_o         = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem.mem_req_o  = reset;
        mem.mem_addr_o = pc_i;
      end
      ST_DECODE: begin
        readin_a_o    = 1'b1;
        readin_b_o    = 1'b1;
        readin_pass_o = 1'b1;
      end
      ST_MEMORY: begin
        mem.mem_req_o  = reset;
        mem.mem_we_o   = reset && is_store_i;
        mem.mem_addr_o = y_i[ADDR_WIDTH-1:0];
      end
      ST_WRITEBACK: begin
        pc_readin_o = 1'b1;
        wd_q_o      = !is_store_i;
      end
      ST_HALT:  halted_o = 1'b1;
      default:  halted_o = 1'b0;
    endcase
  end

  assign stage_o   = state_r;
  assign ir_o      = ir_r;
  assign retired_o = retired_r;
  assign bus_err_o = bus_err_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer: each instruction is expanded into its expected
// stage timeline from the sequencing rules and compared cycle by cycle.
module tb_stage_sequencer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_i;
  logic [DW-1:0] y_i;
  logic          is_load_i, is_store_i;
  logic [DW-1:0] ir_o;
  logic [2:0]    stage_o;
  logic          readin_a_o, readin_b_o, readin_pass_o, wd_q_o, pc_readin_o;
  logic          halt_req_i, step_i, halted_o, bus_err_o;
  logic [CW-1:0] retired_o;

  int n_checks = 0;
  int n_fail   = 0;
  int model_retired = 0;

  stage_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_bus ();

  stage_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(15), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .mem(mem_bus.master),
    .pc_i(pc_i), .y_i(y_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .ir_o(ir_o), .stage_o(stage_o),
    .readin_a_o(readin_a_o), .readin_b_o(readin_b_o), .readin_pass_o(readin_pass_o),
    .wd_q_o(wd_q_o), .pc_readin_o(pc_readin_o),
    .halt_req_i(halt_req_i), .step_i(step_i), .halted_o(halted_o),
    .bus_err_o(bus_err_o), .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 load+store (acts as store)
  task automatic run_instr(input int kind, input int wf, input int wm,
                           input logic [AW-1:0] pc, input logic [DW-1:0] data,
                           input logic [DW-1:0] y, input bit halt_at_exec);
    int  exp_q[$];
    bit  rdy_q[$];
    bit  ld, st, dec, wb;
    ld = (kind == 1) || (kind == 3);
    st = (kind >= 2);
    for (int k = 0; k <= wf; k++) begin exp_q.push_back(0); rdy_q.push_back(k == wf); end
    exp_q.push_back(1); rdy_q.push_back(1'b0);
    exp_q.push_back(2); rdy_q.push_back(1'b0);
    if (ld || st)
      for (int k = 0; k <= wm; k++) begin exp_q.push_back(3); rdy_q.push_back(k == wm); end
    exp_q.push_back(4); rdy_q.push_back(1'b0);

    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        pc_i = pc; y_i = y; is_load_i = ld; is_store_i = st;
        mem_bus.mem_data_i = data; step_i = 1'b0;
      end
      mem_bus.mem_ready_i = rdy_q[i];
      if (exp_q[i] != 0) mem_bus.mem_data_i = $urandom;
      if (halt_at_exec && exp_q[i] == 2) halt_req_i = 1'b1;
      #1;
      dec = (exp_q[i] == 1);
      wb  = (exp_q[i] == 4);
      if (i == 0) check_eq("retired", retired_o, model_retired);
      check_eq("stage", stage_o, exp_q[i]);
      check_eq("mem_req", mem_bus.mem_req_o, (exp_q[i] == 0) || (exp_q[i] == 3));
      check_eq("mem_we", mem_bus.mem_we_o, (exp_q[i] == 3) && st);
      if (exp_q[i] == 0) check_eq("addr_fetch", mem_bus.mem_addr_o, pc);
      if (exp_q[i] == 3) check_eq("addr_mem", mem_bus.mem_addr_o, y);
      if (exp_q[i] != 0) check_eq("ir", ir_o, data);
      check_eq("readin", {readin_a_o, readin_b_o, readin_pass_o}, {dec, dec, dec});
      check_eq("pc_readin", pc_readin_o, wb);
      check_eq("wd_q", wd_q_o, wb && !st);
      check_eq("halted", halted_o, 1'b0);
    end
    model_retired = (model_retired + 1) % (1 << CW);
  endtask

  task automatic check_halt_cycle();
    @(negedge clk);
    #1;
    check_eq("halt_stage", stage_o, 3'd5);
    check_eq("halt_flag", halted_o, 1'b1);
    check_eq("halt_req_out", mem_bus.mem_req_o, 1'b0);
    check_eq("halt_strobes", {readin_a_o, readin_b_o, readin_pass_o, wd_q_o, pc_readin_o}, 5'd0);
    check_eq("halt_retired", retired_o, model_retired);
  endtask

  initial begin
    bit reached;
    reset = 1'b0; pc_i = '0; y_i = '0; is_load_i = 1'b0; is_store_i = 1'b0;
    halt_req_i = 1'b0; step_i = 1'b0;
    mem_bus.mem_ready_i = 1'b0; mem_bus.mem_data_i = '0;
    #12;
    check_eq("rst_stage", stage_o, 3'd0);
    check_eq("rst_req", mem_bus.mem_req_o, 1'b0);
    check_eq("rst_we", mem_bus.mem_we_o, 1'b0);
    check_eq("rst_ir", ir_o, 32'd0);
    check_eq("rst_retired", retired_o, 4'd0);
    check_eq("rst_bus_err", bus_err_o, 1'b0);
    check_eq("rst_halted", halted_o, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    run_instr(0, 0, 0, 32'h10, 32'h00A00093, 32'h0, 1'b0);
    run_instr(2, 0, 3, 32'h14, 32'h12345678, 32'h200, 1'b0);
    run_instr(1, 15, 15, 32'h18, 32'hCAFEF00D, 32'h404, 1'b0);
    run_instr(3, 1, 2, 32'h1C, 32'h0BADBEEF, 32'h808, 1'b0);

    for (int n = 0; n < 20; n++)
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, $urandom, $urandom, 1'b0);

    // Debug halt, single step, then release with step held (release wins).
    run_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom, $urandom, $urandom, 1'b1);
    for (int k = 0; k < 3; k++) check_halt_cycle();
    @(negedge clk);
    step_i = 1'b1;
    #1;
    check_eq("step_stage", stage_o, 3'd5);
    run_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom, $urandom, $urandom, 1'b0);
    check_halt_cycle();
    check_halt_cycle();
    @(negedge clk);
    halt_req_i = 1'b0; step_i = 1'b1;
    #1;
    check_eq("release_stage", stage_o, 3'd5);
    run_instr(0, 0, 0, 32'h40, 32'h00000013, 32'h0, 1'b0);
    run_instr(1, 0, 0, 32'h44, 32'h00002003, 32'h100, 1'b0);

    // Asynchronous reset in the middle of a store.
    @(negedge clk);
    pc_i = 32'h50; y_i = 32'h300; is_load_i = 1'b0; is_store_i = 1'b1;
    mem_bus.mem_ready_i = 1'b1; mem_bus.mem_data_i = 32'h55;
    reached = 1'b0;
    for (int k = 0; k < 10 && !reached; k++) begin
      @(negedge clk);
      mem_bus.mem_ready_i = 1'b0;
      #1;
      reached = (stage_o == 3'd3);
    end
    check_eq("reach_memory", reached, 1'b1);
    check_eq("mid_we", mem_bus.mem_we_o, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_req", mem_bus.mem_req_o, 1'b0);
    check_eq("async_we", mem_bus.mem_we_o, 1'b0);
    check_eq("async_stage", stage_o, 3'd0);
    check_eq("async_retired", retired_o, 4'd0);
    check_eq("async_ir", ir_o, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_retired = 0;

    // Exactly 16 retirements wrap the 4-bit counter; checked at the next instruction start.
    for (int n = 0; n < 16; n++)
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom, $urandom, $urandom, 1'b0);
    run_instr(0, 0, 0, 32'h60, 32'h00100093, 32'h0, 1'b0);

    // Fetch never completes: 16 waiting cycles then sticky ERROR.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      pc_i = 32'h70; mem_bus.mem_ready_i = 1'b0;
      #1;
      check_eq("wait_stage", stage_o, 3'd0);
      check_eq("wait_err", bus_err_o, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_bus.mem_ready_i = 1'($urandom_range(0, 1));
      halt_req_i = 1'($urandom_range(0, 1));
      #1;
      check_eq("err_stage", stage_o, 3'd6);
      check_eq("err_flag", bus_err_o, 1'b1);
      check_eq("err_req", mem_bus.mem_req_o, 1'b0);
      check_eq("err_halted", halted_o, 1'b0);
      check_eq("err_strobes", {readin_a_o, readin_b_o, readin_pass_o, wd_q_o, pc_readin_o}, 5'd0);
    end
    halt_req_i = 1'b0;
    mem_bus.mem_ready_i = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_eq("err_rst_flag", bus_err_o, 1'b0);
    check_eq("err_rst_stage", stage_o, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    model_retired = 0;
    run_instr(2, 0, 1, 32'h80, 32'hABCD0123, 32'h900, 1'b0);
    run_instr(0, 0, 0, 32'h84, 32'h00000033, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
